// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulate stage: op encoding and default widths.
package mac_pkg;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_ACC_WIDTH = 40;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_MAC = 2'b01,
        OP_MSU = 2'b10,
        OP_CLR = 2'b11
    } op_e;

endpackage

// File: rtl/mac_acc_alu.sv
// Combinational accumulator ALU: extends the product, performs load/add/sub/clear,
// detects signed/unsigned overflow and, when MAC_SATURATE_EN is defined, saturates.
module mac_acc_alu
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]     i_prod,
    input  logic                 i_signed,
    input  op_e                  i_op,
    output logic [ACC_WIDTH-1:0] o_next_acc,
    output logic                 o_ovf
);

    logic [ACC_WIDTH-1:0] w_ext;
    logic [ACC_WIDTH:0]   w_sum;
    logic [ACC_WIDTH:0]   w_diff;
    logic                 w_acc_s;
    logic                 w_ext_s;
    logic                 w_sum_s;
    logic                 w_diff_s;

    assign w_ext    = i_signed ? {{(ACC_WIDTH-WIDTH){i_prod[WIDTH-1]}}, i_prod}
                               : {{(ACC_WIDTH-WIDTH){1'b0}}, i_prod};
    assign w_sum    = {1'b0, i_acc} + {1'b0, w_ext};
    assign w_diff   = {1'b0, i_acc} - {1'b0, w_ext};
    assign w_acc_s  = i_acc[ACC_WIDTH-1];
    assign w_ext_s  = w_ext[ACC_WIDTH-1];
    assign w_sum_s  = w_sum[ACC_WIDTH-1];
    assign w_diff_s = w_diff[ACC_WIDTH-1];

    // Select the op result and its overflow condition, then optionally saturate.
    always_comb begin
        o_next_acc = i_acc;
        o_ovf      = 1'b0;
        unique case (i_op)
            OP_MUL: o_next_acc = w_ext;
            OP_MAC: begin
                o_next_acc = w_sum[ACC_WIDTH-1:0];
                o_ovf      = i_signed ? ((w_acc_s == w_ext_s) && (w_sum_s != w_acc_s))
                                      : w_sum[ACC_WIDTH];
            end
            OP_MSU: begin
                o_next_acc = w_diff[ACC_WIDTH-1:0];
                o_ovf      = i_signed ? ((w_acc_s != w_ext_s) && (w_diff_s != w_acc_s))
                                      : w_diff[ACC_WIDTH];
            end
            OP_CLR: o_next_acc = '0;
        endcase
`ifdef MAC_SATURATE_EN
        // A signed overflow always pushes away from the sign of acc, so acc's sign picks the rail.
        if (o_ovf) begin
            if (i_signed)
                o_next_acc = w_acc_s ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            else
                o_next_acc = (i_op == OP_MSU) ? '0 : '1;
        end
`endif
    end

endmodule

// File: rtl/mac_accumulate_stage.sv
// Two-stage MAC back end: S1 input register, S2 accumulator/output register,
// valid/ready handshake on both sides. Optional saturation via MAC_SATURATE_EN.
module mac_accumulate_stage
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_prod,
    input  logic                 in_signed,
    input  logic [1:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_result,
    output logic                 out_neg,
    output logic                 out_zero,
    output logic                 out_ovf
);

    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_prod;
    logic                 r_s1_signed;
    op_e                  r_s1_op;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_neg;
    logic                 r_zero;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_adv;
    logic [ACC_WIDTH-1:0] w_next_acc;
    logic                 w_alu_ovf;
    logic                 w_keeps_ovf;

    assign in_ready    = !rst && (!r_s1_valid || !r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_adv       = r_s1_valid && (!r_out_valid || out_ready);
    assign w_keeps_ovf = (r_s1_op == OP_MAC) || (r_s1_op == OP_MSU);

    mac_acc_alu #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_alu (
        .i_acc      (r_acc),
        .i_prod     (r_s1_prod),
        .i_signed   (r_s1_signed),
        .i_op       (r_s1_op),
        .o_next_acc (w_next_acc),
        .o_ovf      (w_alu_ovf)
    );

    // S1 input register: fills on accept, empties when its op moves into S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_prod   <= '0;
            r_s1_signed <= 1'b0;
            r_s1_op     <= OP_MUL;
        end else if (w_accept) begin
            r_s1_valid  <= 1'b1;
            r_s1_prod   <= in_prod;
            r_s1_signed <= in_signed;
            r_s1_op     <= op_e'(in_op);
        end else if (w_adv) begin
            r_s1_valid  <= 1'b0;
        end
    end

    // S2 accumulator doubles as the output register; it updates only when a new beat is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_neg       <= 1'b0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= 1'b1;
            r_acc       <= w_next_acc;
            r_neg       <= r_s1_signed && w_next_acc[ACC_WIDTH-1];
            r_zero      <= (w_next_acc == '0);
            r_ovf       <= w_keeps_ovf ? (r_ovf || w_alu_ovf) : 1'b0;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_acc;
    assign out_neg    = r_neg;
    assign out_zero   = r_zero;
    assign out_ovf    = r_ovf;

endmodule

// File: tb/tb_mac_accumulate_stage.sv
// Self-checking bench for mac_accumulate_stage: table-driven vectors plus
// hand-written sequences, with a reference-model scoreboard on every beat.
module tb_mac_accumulate_stage;
    import mac_pkg::*;

    localparam int W  = 32;
    localparam int AW = 40;
    localparam longint MAXS = 64'sd549755813887;
    localparam longint MINS = -64'sd549755813888;
    localparam longint MAXU = 64'sd1099511627775;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_prod;
    logic          in_signed;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_result;
    logic          out_neg;
    logic          out_zero;
    logic          out_ovf;

    always #5 clk = ~clk;

    mac_accumulate_stage #(
        .WIDTH     (W),
        .ACC_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_prod    (in_prod),
        .in_signed  (in_signed),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_neg    (out_neg),
        .out_zero   (out_zero),
        .out_ovf    (out_ovf)
    );

    typedef struct {
        logic [AW-1:0] res;
        logic          neg;
        logic          zero;
        logic          ovf;
        int            acyc;
    } beat_t;

    typedef struct {
        logic [1:0]    op;
        logic          sg;
        logic [W-1:0]  p;
        logic [AW-1:0] res;
        logic          ovf;
    } vec_t;

    beat_t         sb[$];
    beat_t         last;
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            nbeats = 0;
    logic [AW-1:0] m_acc = '0;
    logic          m_ovf = 1'b0;
    logic          chk_lat = 1'b0;
    logic          saw_block = 1'b0;
    logic          arm_first = 1'b0;
    int            first_beat_cyc = 0;
    int            last_beat_cyc = 0;
    logic          stall_prev = 1'b0;
    logic [AW+2:0] stall_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model evaluated at acceptance time with 64-bit integer arithmetic.
    task automatic model_push(input logic [1:0] op, input logic sg, input logic [W-1:0] p);
        longint a, e, r;
        logic   o;
        beat_t  b;
        if (sg) begin
            a = longint'($signed(m_acc));
            e = longint'($signed(p));
        end else begin
            a = longint'({24'd0, m_acc});
            e = longint'({32'd0, p});
        end
        o = 1'b0;
        case (op)
            OP_MUL:  r = e;
            OP_MAC:  r = a + e;
            OP_MSU:  r = a - e;
            default: r = 0;
        endcase
        if (op == OP_MAC || op == OP_MSU) begin
            if (sg) o = (r > MAXS) || (r < MINS);
            else    o = (r > MAXU) || (r < 0);
`ifdef MAC_SATURATE_EN
            if (o) begin
                if (sg) r = (r > MAXS) ? MAXS : MINS;
                else    r = (r < 0) ? 0 : MAXU;
            end
`endif
        end
        m_acc  = r[AW-1:0];
        m_ovf  = (op == OP_MAC || op == OP_MSU) ? (m_ovf | o) : 1'b0;
        b.res  = m_acc;
        b.neg  = sg & m_acc[AW-1];
        b.zero = (m_acc == '0);
        b.ovf  = m_ovf;
        b.acyc = cyc;
        sb.push_back(b);
    endtask

    // Monitor: samples handshakes on the falling edge, feeds the model and scores beats.
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (rst) begin
            sb.delete();
            m_acc      = '0;
            m_ovf      = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (!in_ready) saw_block = 1'b1;
            if (stall_prev && out_valid)
                chk("stall_hold", {21'd0, out_ovf, out_zero, out_neg, out_result}, {21'd0, stall_val});
            stall_prev = out_valid && !out_ready;
            stall_val  = {out_ovf, out_zero, out_neg, out_result};
            if (in_valid && in_ready) model_push(in_op, in_signed, in_prod);
            if (out_valid && out_ready) begin
                nbeats++;
                last_beat_cyc = cyc;
                if (arm_first) begin
                    first_beat_cyc = cyc;
                    arm_first = 1'b0;
                end
                last.res = out_result;
                last.ovf = out_ovf;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_unexpected: got result 0x%0h with empty scoreboard", out_result);
                end else begin
                    e = sb.pop_front();
                    chk("sb_result", {24'd0, out_result}, {24'd0, e.res});
                    chk("sb_flags", {61'd0, out_neg, out_zero, out_ovf}, {61'd0, e.neg, e.zero, e.ovf});
                    if (chk_lat) chk("latency", 64'(cyc - e.acyc), 64'd2);
                end
            end
        end
    end

    // Drives one op and returns (at posedge+1) once it has been accepted; in_valid stays high.
    task automatic send(input logic [1:0] op, input logic sg, input logic [W-1:0] p);
        int t = 0;
        in_valid  = 1'b1;
        in_op     = op;
        in_signed = sg;
        in_prod   = p;
        forever begin
            @(negedge clk);
            t++;
            if (in_ready) break;
            if (t > 100) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 2000) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d beats still pending", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vt[10];
    int   n0;

    initial begin
        vt[0] = '{OP_MUL, 1'b1, 32'h0000_0006, 40'h00_0000_0006, 1'b0};
        vt[1] = '{OP_MAC, 1'b1, 32'hFFFF_FFFE, 40'h00_0000_0004, 1'b0};
        vt[2] = '{OP_MUL, 1'b0, 32'h0000_0001, 40'h00_0000_0001, 1'b0};
`ifdef MAC_SATURATE_EN
        vt[3] = '{OP_MSU, 1'b0, 32'h0000_0002, 40'h00_0000_0000, 1'b1};
`else
        vt[3] = '{OP_MSU, 1'b0, 32'h0000_0002, 40'hFF_FFFF_FFFF, 1'b1};
`endif
        vt[4] = '{OP_CLR, 1'b0, 32'h1234_5678, 40'h00_0000_0000, 1'b0};
        vt[5] = '{OP_MUL, 1'b1, 32'h8000_0000, 40'hFF_8000_0000, 1'b0};
        vt[6] = '{OP_MSU, 1'b1, 32'h0000_0001, 40'hFF_7FFF_FFFF, 1'b0};
`ifdef MAC_SATURATE_EN
        vt[7] = '{OP_MAC, 1'b0, 32'hFFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b1};
        vt[8] = '{OP_MAC, 1'b1, 32'h0000_0001, 40'h00_0000_0000, 1'b1};
`else
        vt[7] = '{OP_MAC, 1'b0, 32'hFFFF_FFFF, 40'h00_7FFF_FFFE, 1'b1};
        vt[8] = '{OP_MAC, 1'b1, 32'h0000_0001, 40'h00_7FFF_FFFF, 1'b1};
`endif
        vt[9] = '{OP_MUL, 1'b0, 32'h0000_0005, 40'h00_0000_0005, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_signed = 1'b0; in_prod = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", {24'd0, out_result}, 64'd0);
        chk("rst_flags", {61'd0, out_neg, out_zero, out_ovf}, 64'b010);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;

        // Table vectors: one op at a time, each checked against its fixed expectation.
        chk_lat = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(vt[i].op, vt[i].sg, vt[i].p);
            in_valid = 1'b0;
            wait_idle();
            chk($sformatf("vec%0d_result", i), {24'd0, last.res}, {24'd0, vt[i].res});
            chk($sformatf("vec%0d_ovf", i), {63'd0, last.ovf}, {63'd0, vt[i].ovf});
        end
        chk_lat = 1'b0;

        // Signed positive overflow after 256 accumulations, then CLR.
        send(OP_MUL, 1'b1, 32'h7FFF_FFFF);
        for (int i = 0; i < 256; i++) send(OP_MAC, 1'b1, 32'h7FFF_FFFF);
        in_valid = 1'b0;
        wait_idle();
`ifdef MAC_SATURATE_EN
        chk("sovf_result", {24'd0, last.res}, 64'h7F_FFFF_FFFF);
`else
        chk("sovf_result", {24'd0, last.res}, 64'h80_7FFF_FEFF);
`endif
        chk("sovf_ovf", {63'd0, last.ovf}, 64'd1);
        send(OP_CLR, 1'b1, 32'h7FFF_FFFF);
        in_valid = 1'b0;
        wait_idle();
        chk("clr_result", {24'd0, last.res}, 64'd0);
        chk("clr_ovf", {63'd0, last.ovf}, 64'd0);

        // Backpressure mid-stream: four MACs of 1 with out_ready low for 3 cycles.
        saw_block = 1'b0;
        n0 = nbeats;
        fork
            begin
                for (int i = 0; i < 4; i++) send(OP_MAC, 1'b1, 32'd1);
                in_valid = 1'b0;
            end
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_idle();
        chk("bp_beats", 64'(nbeats - n0), 64'd4);
        chk("bp_result", {24'd0, last.res}, 64'd4);
        chk("bp_in_ready_drop", {63'd0, saw_block}, 64'd1);

        // Reset with both stages full discards everything in flight.
        out_ready = 1'b0;
        send(OP_MAC, 1'b1, 32'd7);
        send(OP_MAC, 1'b1, 32'd9);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_result", {24'd0, out_result}, 64'd0);
        chk("midrst_zero", {63'd0, out_zero}, 64'd1);
        out_ready = 1'b1;
        send(OP_MAC, 1'b1, 32'd5);
        in_valid = 1'b0;
        wait_idle();
        chk("postrst_result", {24'd0, last.res}, 64'd5);

        // Throughput: 16 back-to-back MACs of 1 must stream one beat per cycle.
        send(OP_CLR, 1'b0, 32'd0);
        in_valid = 1'b0;
        wait_idle();
        saw_block = 1'b0;
        chk_lat   = 1'b1;
        arm_first = 1'b1;
        n0 = nbeats;
        for (int i = 0; i < 16; i++) send(OP_MAC, 1'b0, 32'd1);
        in_valid = 1'b0;
        wait_idle();
        chk_lat = 1'b0;
        chk("tp_beats", 64'(nbeats - n0), 64'd16);
        chk("tp_consecutive", 64'(last_beat_cyc - first_beat_cyc), 64'd15);
        chk("tp_result", {24'd0, last.res}, 64'd16);
        chk("tp_no_block", {63'd0, saw_block}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_accumulate_stage.md
# mac_accumulate_stage

Pipelined multiply-accumulate back end, directly downstream of the combinational 16x16 Booth multiplier top. Registers the 32-bit product and its flags, then loads, accumulates, subtracts or clears a wide accumulator, and presents the result through a valid/ready handshake. Breaks the long Booth/tree/CLA path with a register and adds MAC capability to the ALU datapath.

## Interface
- WIDTH, 32: product width from the multiplier.
- ACC_WIDTH, 40: accumulator/result width; must be greater than WIDTH.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product and op are valid.
- in_ready  output  1  stage accepts input this cycle.
- in_prod  input  WIDTH  product from the multiplier.
- in_signed  input  1  1 = signed product and arithmetic, 0 = unsigned.
- in_op  input  2  00 MUL (load), 01 MAC (acc + p), 10 MSU (acc - p), 11 CLR.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  ACC_WIDTH  accumulator value after the op.
- out_neg  output  1  out_result[ACC_WIDTH-1] when the op is signed, else 0.
- out_zero  output  1  out_result == 0.
- out_ovf  output  1  sticky overflow flag.

## Operation
- S1: the input register captures in_prod, in_signed and in_op on in_valid && in_ready.
- S2: the accumulator register is also the output register and updates when S1 transfers to S2.
- Extension: signed ops sign-extend in_prod to ACC_WIDTH; unsigned ops zero-extend it.
- MUL: acc = ext. Clears out_ovf.
- MAC: acc = acc + ext, wrapping modulo 2^ACC_WIDTH.
  - Signed overflow: both operands have the same sign and the result sign differs.
  - Unsigned overflow: carry out of bit ACC_WIDTH-1.
- MSU: acc = acc - ext.
  - Signed overflow: operand signs differ and the result sign differs from acc.
  - Unsigned overflow: borrow.
- CLR: acc = 0. Clears out_ovf. The product is ignored, but the op still produces an output beat.
- out_ovf is sticky: it ORs in each MAC/MSU overflow and clears only on MUL, CLR or rst.
- Every accepted op produces exactly one output beat, in order.
- No ops are dropped or duplicated under backpressure.

## Timing
- in_ready = !s1_valid || !out_valid || out_ready (combinational). It is held 0 while rst is high.
- S1 advances to S2 when s1_valid && (!out_valid || out_ready).
- Latency: accept at edge N, out_valid high after edge N+1 (2-cycle pipeline). Throughput is 1 op/cycle with out_ready held high.
- While out_valid && !out_ready: out_result, out_neg, out_zero and out_ovf hold stable. S1 holds its contents and in_ready = 0 once S1 is full.
- Back-to-back MACs use the just-updated acc with no bubble, because acc is updated in the same edge that issues the beat.
- Simultaneous out_ready and new input while both stages are full: S2 loads from S1 and S1 loads the new input in the same edge.
- Reset values: out_valid 0, s1_valid 0, out_result 0, out_neg 0, out_zero 1, out_ovf 0.
- rst mid-operation discards all in-flight ops. rst overrides any same-cycle handshake.

## Configuration
- MAC_SATURATE_EN defined: on MAC/MSU overflow, acc saturates instead of wrapping. out_ovf is set as usual.
  - Signed: saturates to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - Unsigned: saturates to all-ones, or to 0 on borrow.
- MAC_SATURATE_EN undefined: modular wrap. The overflow flag behaviour is identical in both builds.

## Structure
- Shared package mac_pkg holds:
  - the op encoding constants (OP_MUL, OP_MAC, OP_MSU, OP_CLR);
  - the default ACC_WIDTH.
- One sub-module, mac_acc_alu, is combinational: it computes extend, add/sub, overflow detection and optional saturation, and returns next_acc and ovf.
- The top level holds the S1 register, the acc/output register and the handshake logic.

## Test plan
- Signed MUL then MAC: p = 0x0000_0006 (MUL), then p = 0xFFFF_FFFE signed (MAC), out_ready = 1 -> results 6 then 4. Beats land 2 cycles after each accept; out_neg 0, out_ovf 0.
- Unsigned MSU underflow: MUL p = 1, then MSU p = 2 unsigned.
  - Without MAC_SATURATE_EN: result 0xFF_FFFF_FFFF, out_ovf 1.
  - With MAC_SATURATE_EN: result 0, out_zero 1, out_ovf 1.
- Signed positive overflow: MUL 0x7FFF_FFFF, then 256 MACs of 0x7FFF_FFFF with ACC_WIDTH 40 -> out_ovf rises on the wrapping beat and stays 1. A following CLR gives result 0, out_ovf 0.
- Backpressure: 4 back-to-back MACs of p = 1 with out_ready low for 3 cycles mid-stream.
  - out_result stays stable while stalled.
  - in_ready drops with both stages full.
  - Final beats are 1, 2, 3, 4 in order with no loss.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> next cycle out_valid 0, out_result 0, out_zero 1. The next MAC of p = 5 returns 5.
- Throughput: 16 MACs of p = 1 with out_ready = 1 -> 16 consecutive out_valid cycles starting 2 cycles after the first accept, final result 16.
